// File: rtl/tetris_pkg.sv
// tetris_pkg: shared state/piece types, constants and LFSR helpers for the game controller
package tetris_pkg;
  typedef enum logic [2:0] {IDLE, SPAWN, FALL, CLEAR, OVER} game_state_t;
  typedef enum logic [3:0] {I = 4'd0, O, T, S, Z, J, L} tetromino_t;
  localparam logic [7:0] LFSR_SEED = 8'h5A;
  localparam logic [3:0] MAX_LEVEL = 4'd15;
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  // the unused code 7 folds onto the upper bits so every ID stays reachable
  function automatic tetromino_t piece_id(input logic [7:0] v);
    return tetromino_t'(v[2:0] != 3'd7 ? {1'b0, v[2:0]} : v[5:3] == 3'd7 ? 4'd0 : {1'b0, v[5:3]});
  endfunction
endpackage

// File: rtl/tetris_game_ctrl_if.sv
// tetris_game_ctrl_if: input-layer, grid and status signals around the game controller
interface tetris_game_ctrl_if;
  logic start, btn_left, btn_right, btn_down, btn_rotate;
  logic piece_locked, row_cleared, grid_game_over;
  logic spawn, step_down, move_left, move_right, rotate, playing, game_over;
  logic [3:0] next_tetromino, level;
  logic [15:0] lines;
  modport master (
    output start, btn_left, btn_right, btn_down, btn_rotate, piece_locked, row_cleared, grid_game_over,
    input  spawn, next_tetromino, step_down, move_left, move_right, rotate, lines, level, playing, game_over
  );
  modport slave (
    input  start, btn_left, btn_right, btn_down, btn_rotate, piece_locked, row_cleared, grid_game_over,
    output spawn, next_tetromino, step_down, move_left, move_right, rotate, lines, level, playing, game_over
  );
endinterface

// File: rtl/input_repeater.sv
// input_repeater: request on a button's rising edge, then auto-repeat while it stays held
module input_repeater #(
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);
  logic prev, rep, fire;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    fire = prev && cnt == (rep ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY));
    req = btn && (!prev || fire);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= 1'b0;
      rep <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= btn;
      rep <= btn && (rep || fire);
      cnt <= !btn ? '0 : req ? CNT_W'(1) : cnt + CNT_W'(1);
    end
endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: game-flow FSM sequencing spawn, gravity, player commands and line/level accounting
module tetris_game_ctrl #(
  parameter int GRAV_BASE    = 40_000_000,
  parameter int GRAV_STEP    = 2_000_000,
  parameter int GRAV_MIN     = 4_000_000,
  parameter int SOFT_PERIOD  = 8_000_000,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CLEAR_PAUSE  = 1_000_000,
  parameter int CNT_W        = 26
) (
  input logic clk,
  input logic reset,
  tetris_game_ctrl_if.slave bus
);
  import tetris_pkg::*;
  game_state_t state, state_nx;
  tetromino_t held_id;
  logic [7:0] lfsr;
  logic [CNT_W-1:0] grav_cnt, clr_cnt, drop, period;
  logic [15:0] lines;
  logic [3:0] level, lil;
  logic pend_step, pend_rot, pend_l, pend_r, rot_prev;
  logic req_step, req_rot, req_l, req_r;
  logic iss_step, iss_rot, iss_l, iss_r;
  logic in_fall, keep, restart, count_row;
  input_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_left (
    .clk(clk), .rst(reset), .btn(bus.btn_left && !bus.btn_right), .req(req_l)
  );
  input_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_right (
    .clk(clk), .rst(reset), .btn(bus.btn_right && !bus.btn_left), .req(req_r)
  );
  always_comb begin
    drop = CNT_W'(level) * CNT_W'(GRAV_STEP);
    period = drop >= CNT_W'(GRAV_BASE - GRAV_MIN) ? CNT_W'(GRAV_MIN) : CNT_W'(GRAV_BASE) - drop;
    period = bus.btn_down && period > CNT_W'(SOFT_PERIOD) ? CNT_W'(SOFT_PERIOD) : period;
    in_fall = state == FALL;
    req_step = in_fall && grav_cnt >= period - CNT_W'(1);
    req_rot = bus.btn_rotate && !rot_prev;
    iss_step = in_fall && pend_step;
    iss_rot = in_fall && pend_rot && !pend_step;
    iss_l = in_fall && pend_l && !pend_step && !pend_rot;
    iss_r = in_fall && pend_r && !pend_step && !pend_rot && !pend_l;
    restart = bus.start && (state == IDLE || state == OVER);
    count_row = bus.row_cleared && (state == FALL || state == CLEAR);
    state_nx = state;
    unique case (state)
      IDLE, OVER: state_nx = bus.start ? SPAWN : state;
      SPAWN:      state_nx = FALL;
      FALL:       state_nx = bus.piece_locked ? CLEAR : FALL;
      CLEAR:      state_nx = clr_cnt >= CNT_W'(CLEAR_PAUSE - 1) ? SPAWN : CLEAR;
      default:    state_nx = IDLE;
    endcase
    if (bus.grid_game_over && state inside {SPAWN, FALL, CLEAR}) state_nx = OVER;
    keep = in_fall && state_nx == FALL;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      held_id <= I;
      grav_cnt <= '0;
      clr_cnt <= '0;
      {pend_step, pend_rot, pend_l, pend_r, rot_prev} <= '0;
      lines <= '0;
      level <= '0;
      lil <= '0;
    end else begin
      state <= state_nx;
      lfsr <= lfsr_next(lfsr);
      rot_prev <= bus.btn_rotate;
      held_id <= state == SPAWN ? piece_id(lfsr) : held_id;
      grav_cnt <= state == SPAWN || req_step ? '0 : in_fall ? grav_cnt + CNT_W'(1) : grav_cnt;
      clr_cnt <= state == CLEAR ? clr_cnt + CNT_W'(1) : '0;
      pend_step <= keep && ((pend_step && !iss_step) || req_step);
      pend_rot <= keep && ((pend_rot && !iss_rot) || req_rot);
      pend_l <= keep && ((pend_l && !iss_l) || req_l);
      pend_r <= keep && ((pend_r && !iss_r) || req_r);
      if (restart) begin
        lines <= '0;
        level <= '0;
        lil <= '0;
      end else if (count_row) begin
        lines <= lines == 16'hFFFF ? lines : lines + 16'd1;
        lil <= lil == 4'd9 ? 4'd0 : lil + 4'd1;
        level <= lil == 4'd9 && level != MAX_LEVEL ? level + 4'd1 : level;
      end
    end
  assign bus.spawn = state == SPAWN;
  assign bus.next_tetromino = state == SPAWN ? piece_id(lfsr) : held_id;
  assign bus.step_down = iss_step;
  assign bus.rotate = iss_rot;
  assign bus.move_left = iss_l;
  assign bus.move_right = iss_r;
  assign bus.lines = lines;
  assign bus.level = level;
  assign bus.playing = state inside {SPAWN, FALL, CLEAR};
  assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: randomized scoreboard bench against a cycle-level behavioural game model
module tb_tetris_game_ctrl;
  localparam int GB = 20, GS = 4, GM = 8, SP = 4, RD = 6, RR = 3, CP = 5;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_CLEAR = 3, P_OVER = 4;
  typedef struct {int cyc; logic [4:0] mask;} pulse_t;
  typedef struct {int cyc; logic [15:0] lines; logic [3:0] level; logic [3:0] tet; logic playing; logic over;} stat_t;
  logic clk = 1'b0;
  logic s_reset = 1'b1, s_start = 1'b0, s_left = 1'b0, s_right = 1'b0, s_down = 1'b0, s_rot = 1'b0;
  logic s_lock = 1'b0, s_row = 1'b0, s_ggo = 1'b0;
  pulse_t pq[$];
  stat_t sq[$];
  pulse_t pe;
  stat_t se;
  logic [4:0] pm;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_ph, m_lf, m_age, m_clr, m_hl, m_hr, m_lines, m_tet;
  bit m_rotp, m_ps, m_pt, m_pl, m_pr;
  tetris_game_ctrl_if bus();
  assign bus.start = s_start;
  assign bus.btn_left = s_left;
  assign bus.btn_right = s_right;
  assign bus.btn_down = s_down;
  assign bus.btn_rotate = s_rot;
  assign bus.piece_locked = s_lock;
  assign bus.row_cleared = s_row;
  assign bus.grid_game_over = s_ggo;
  tetris_game_ctrl #(.GRAV_BASE(GB), .GRAV_STEP(GS), .GRAV_MIN(GM), .SOFT_PERIOD(SP), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .CLEAR_PAUSE(CP), .CNT_W(8)) dut (.clk(clk), .reset(s_reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int lf_next(int v);
    return ((v << 1) & 255) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
  endfunction
  function automatic int piece(int v);
    return (v & 7) == 7 ? ((v >> 3) & 7) % 7 : v & 7;
  endfunction
  function automatic int m_level();
    return m_lines / 10 > 15 ? 15 : m_lines / 10;
  endfunction
  function automatic bit rep_req(int h);
    return h == 1 || (h > RD && (h - 1 - RD) % RR == 0);
  endfunction
  task automatic m_reset();
    m_ph = P_IDLE; m_lf = 8'h5A; m_age = 0; m_clr = 0; m_hl = 0; m_hr = 0; m_lines = 0; m_tet = 0;
    m_rotp = 0; m_ps = 0; m_pt = 0; m_pl = 0; m_pr = 0;
  endtask
  // push this cycle's expected outputs, then advance the model by the inputs sampled at the next edge
  task automatic model_cycle();
    int lvl, per, hl, hr, nph;
    bit fall, st, rt, ml, mr, rq_s, keep;
    if (s_reset) m_reset();
    fall = m_ph == P_FALL;
    st = fall && m_ps;
    rt = fall && m_pt && !m_ps;
    ml = fall && m_pl && !m_ps && !m_pt;
    mr = fall && m_pr && !m_ps && !m_pt && !m_pl;
    lvl = m_level();
    sq.push_back('{cyc, 16'(m_lines), 4'(lvl), 4'(m_ph == P_SPAWN ? piece(m_lf) : m_tet),
                   m_ph >= P_SPAWN && m_ph <= P_CLEAR, m_ph == P_OVER});
    if (m_ph == P_SPAWN || st || rt || ml || mr) pq.push_back('{cyc, {m_ph == P_SPAWN, st, rt, ml, mr}});
    if (s_reset) return;
    per = GB - lvl * GS < GM ? GM : GB - lvl * GS;
    if (s_down && per > SP) per = SP;
    hl = s_left && !s_right ? m_hl + 1 : 0;
    hr = s_right && !s_left ? m_hr + 1 : 0;
    rq_s = fall && m_age >= per - 1;
    nph = m_ph;
    if ((m_ph == P_IDLE || m_ph == P_OVER) && s_start) nph = P_SPAWN;
    else if (m_ph == P_SPAWN) nph = P_FALL;
    else if (fall && s_lock) nph = P_CLEAR;
    else if (m_ph == P_CLEAR && m_clr == 1) nph = P_SPAWN;
    if (s_ggo && m_ph >= P_SPAWN && m_ph <= P_CLEAR) nph = P_OVER;
    keep = fall && nph == P_FALL;
    m_ps = keep && ((m_ps && !st) || rq_s);
    m_pt = keep && ((m_pt && !rt) || (s_rot && !m_rotp));
    m_pl = keep && ((m_pl && !ml) || rep_req(hl));
    m_pr = keep && ((m_pr && !mr) || rep_req(hr));
    if ((m_ph == P_IDLE || m_ph == P_OVER) && s_start) m_lines = 0;
    else if (s_row && (fall || m_ph == P_CLEAR)) m_lines = m_lines == 65535 ? m_lines : m_lines + 1;
    if (m_ph == P_SPAWN) m_tet = piece(m_lf);
    m_age = m_ph == P_SPAWN ? 0 : fall ? (rq_s ? 0 : m_age + 1) : m_age;
    m_clr = nph == P_CLEAR && m_ph != P_CLEAR ? CP : m_ph == P_CLEAR ? m_clr - 1 : m_clr;
    m_lf = lf_next(m_lf);
    m_hl = hl;
    m_hr = hr;
    m_rotp = s_rot;
    m_ph = nph;
  endtask
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_fall();
    for (int k = 0; k < 200 && m_ph != P_FALL; k++) begin
      s_start = m_ph == P_IDLE || m_ph == P_OVER;
      step();
    end
    s_start = 0;
  endtask
  initial forever begin
    @(negedge clk);
    if (sq.size() > 0) begin
      se = sq.pop_front();
      n_cmp++;
      if ({bus.lines, bus.level, bus.next_tetromino, bus.playing, bus.game_over} !==
          {se.lines, se.level, se.tet, se.playing, se.over}) begin
        n_bad++;
        $display("FAIL status cyc=%0d got lines=%0d level=%0d tet=%0d playing=%b over=%b want lines=%0d level=%0d tet=%0d playing=%b over=%b",
                 cyc, bus.lines, bus.level, bus.next_tetromino, bus.playing, bus.game_over,
                 se.lines, se.level, se.tet, se.playing, se.over);
      end
    end
    pm = {bus.spawn, bus.step_down, bus.rotate, bus.move_left, bus.move_right};
    if (pm != 5'd0) begin
      n_cmp++;
      if (pq.size() == 0) begin
        n_bad++;
        $display("FAIL pulse cyc=%0d got spawn/step/rot/left/right=%b want none pending", cyc, pm);
      end else begin
        pe = pq.pop_front();
        if (pe.cyc != cyc || pe.mask != pm) begin
          n_bad++;
          $display("FAIL pulse cyc=%0d got spawn/step/rot/left/right=%b want cyc=%0d %b", cyc, pm, pe.cyc, pe.mask);
        end
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    repeat (2) step();
    s_reset = 0; s_start = 1; step(); s_start = 0;
    repeat (70) step();
    s_left = 1; repeat (15) step(); s_left = 0; repeat (4) step();
    s_left = 1; s_right = 1; repeat (12) step(); s_left = 0; s_right = 0;
    s_right = 1; repeat (10) step(); s_right = 0;
    for (int k = 0; k < 120; k++) begin
      s_rot = m_ph == P_FALL && m_age == GB - 1;
      step();
    end
    s_rot = 0;
    for (int p = 0; p < 6; p++) begin
      wait_fall(); repeat (3) step();
      s_lock = 1; step(); s_lock = 0;
      s_row = 1; step(); s_row = 0; step(); s_row = 1; step(); s_row = 0;
    end
    wait_fall(); s_down = 1; repeat (30) step(); s_down = 0; repeat (45) step();
    for (int k = 0; k < 2500; k++) begin
      s_left = $urandom_range(7) == 0 ? !s_left : s_left;
      s_right = $urandom_range(9) == 0 ? !s_right : s_right;
      s_down = $urandom_range(11) == 0 ? !s_down : s_down;
      s_rot = $urandom_range(3) == 0 ? !s_rot : s_rot;
      s_lock = m_ph == P_FALL && $urandom_range(30) == 0;
      s_row = $urandom_range(5) == 0;
      s_ggo = $urandom_range(700) == 0;
      s_start = $urandom_range(15) == 0;
      step();
    end
    {s_left, s_right, s_down, s_rot, s_lock, s_row, s_ggo, s_start} = '0;
    wait_fall(); repeat (4) step();
    s_ggo = 1; step(); s_ggo = 0;
    s_left = 1; s_rot = 1; s_down = 1; repeat (12) step(); {s_left, s_rot, s_down} = '0;
    s_start = 1; step(); s_start = 0; repeat (30) step();
    wait_fall(); repeat (5) step();
    s_reset = 1; step(); step(); s_reset = 0; repeat (10) step();
    s_start = 1; step(); s_start = 0; repeat (25) step();
    n_cmp++;
    if (pq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_pulses got %0d unmatched want 0", pq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
